wbbus_master_arbiter: RTL and testbench

WBBUS_MASTER_ARBITER -- requirements
Module: wbbus_master_arbiter

---
 rtl/wbbus_master_arbiter_if.sv | 43 ++++
 rtl/wbbus_master_arbiter.sv | 135 +++++++++++++
 tb/tb_wbbus_master_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbbus_master_arbiter_if.sv
// Wishbone multi-master arbiter bus bundle.
// master: arbiter view; slave: masters + slave-decoder view.
interface wbbus_master_arbiter_if #(
  parameter int WORD    = 16,
  parameter int MASTERS = 2
);
  logic [MASTERS-1:0] mstCyc_i;
  logic [MASTERS-1:0] mstStb_i;
  logic [MASTERS-1:0] mstWe_i;
  logic [WORD-1:0]    mstAdr_i [MASTERS];
  logic [WORD-1:0]    mstDat_i [MASTERS];
  logic [MASTERS-1:0] mstAck_o;
  logic [MASTERS-1:0] mstErr_o;
  logic [MASTERS-1:0] mstGnt_o;
  logic [WORD-1:0]    mstDat_o;
  logic               cyc_o;
  logic               stb_o;
  logic               we_o;
  logic [WORD-1:0]    adr_o;
  logic [WORD-1:0]    dat_o;
  logic               ack_i;
  logic [WORD-1:0]    dat_i;

  modport master (
    input  mstCyc_i, mstStb_i, mstWe_i,
    input  mstAdr_i, mstDat_i,
    output mstAck_o, mstErr_o, mstGnt_o,
    output mstDat_o,
    output cyc_o, stb_o, we_o,
    output adr_o, dat_o,
    input  ack_i, dat_i
  );

  modport slave (
    output mstCyc_i, mstStb_i, mstWe_i,
    output mstAdr_i, mstDat_i,
    input  mstAck_o, mstErr_o, mstGnt_o,
    input  mstDat_o,
    input  cyc_o, stb_o, we_o,
    input  adr_o, dat_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/wbbus_master_arbiter.sv
// Round-robin Wishbone master arbiter, registered grant.
// Optional stall abort enabled by macro WB_TIMEOUT_EN.
module wbbus_master_arbiter #(
  parameter int WORD    = 16,
  parameter int MASTERS = 2,
  parameter int TIMEOUT = 16
) (
  input logic clk_i,
  input logic rst_n_i,
  wbbus_master_arbiter_if.master bus
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [WORD-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    ABORT
  } state_e;

  state_e             state_q;
  logic [IW-1:0]      owner_q;
  logic [IW-1:0]      last_q;
  logic [MASTERS-1:0] gnt_q;

  logic [IW-1:0] pick_d;
  logic          found;
  logic [IW-1:0] cand;
  logic          own;
  logic          own_cyc;
  logic          own_stb;
  logic          stall;

  // first requester after the previous owner, wrapping
  always_comb begin
    pick_d = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= MASTERS; k++) begin
      cand = IW'((int'(last_q) + k) % MASTERS);
      if (!found && bus.mstCyc_i[cand]) begin
        pick_d = cand;
        found  = 1'b1;
      end
    end
  end

  assign own     = (state_q == OWNED);
  assign own_cyc = bus.mstCyc_i[owner_q];
  assign own_stb = bus.mstStb_i[owner_q];
  assign stall   = own && own_stb && !bus.ack_i;

  always_comb begin
    bus.cyc_o    = own && own_cyc;
    bus.stb_o    = own && own_stb;
    bus.we_o     = own && bus.mstWe_i[owner_q];
    bus.adr_o    = own ? bus.mstAdr_i[owner_q] : ZERO;
    bus.dat_o    = own ? bus.mstDat_i[owner_q] : ZERO;
    bus.mstAck_o = '0;
    if (own) begin
      bus.mstAck_o[owner_q] = bus.ack_i && own_stb;
    end
  end

  assign bus.mstGnt_o = gnt_q;
  assign bus.mstDat_o = bus.dat_i;

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmr_q;
  logic          tmo;

  assign tmo          = stall && (tmr_q == CW'(TIMEOUT - 1));
  assign bus.mstErr_o = tmo ? gnt_q : '0;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0) && stall;
  assign bus.mstErr_o   = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(MASTERS - 1);
      gnt_q   <= '0;
`ifdef WB_TIMEOUT_EN
      tmr_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|bus.mstCyc_i) begin
            owner_q <= pick_d;
            gnt_q   <= MASTERS'(1) << pick_d;
            state_q <= OWNED;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            last_q  <= owner_q;
            gnt_q   <= '0;
            state_q <= IDLE;
`ifdef WB_TIMEOUT_EN
            tmr_q   <= '0;
          end else if (tmo) begin
            state_q <= ABORT;
            tmr_q   <= '0;
          end else if (stall) begin
            tmr_q   <= tmr_q + 1'b1;
          end else begin
            tmr_q   <= '0;
`endif
          end
        end
        ABORT: begin
          // grant held until the owner gives up its cycle
          if (!own_cyc) begin
            last_q  <= owner_q;
            gnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbbus_master_arbiter.sv
// Bench for wbbus_master_arbiter: vector table, hand
// sequences and a randomized run against a tenure model.
module tb_wbbus_master_arbiter;

  localparam int WORD = 16;
  localparam int M    = 2;
  localparam int TO   = 16;
  localparam int IW   = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wbbus_master_arbiter_if #(
    .WORD(WORD), .MASTERS(M)
  ) bus ();

  wbbus_master_arbiter #(
    .WORD(WORD), .MASTERS(M), .TIMEOUT(TO)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic [1:0]  we;
    logic        ack;
    logic [15:0] dat;
    logic [1:0]  gnt;
    logic        cyc_o;
    logic [1:0]  ack_o;
    logic [15:0] adr;
  } vec_t;

  vec_t tbl [9];

  // tenure model: who owns, who owned last, stall count
  int m_own;
  int m_last;
  int m_cnt;
  bit m_abort;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic clr_inputs();
    bus.mstCyc_i = '0;
    bus.mstStb_i = '0;
    bus.mstWe_i  = '0;
    bus.ack_i    = 1'b0;
    bus.dat_i    = '0;
    for (int i = 0; i < M; i++) begin
      bus.mstAdr_i[i] = '0;
      bus.mstDat_i[i] = '0;
    end
  endtask

  task automatic model_reset();
    m_own   = -1;
    m_last  = M - 1;
    m_cnt   = 0;
    m_abort = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic model_check(input string nm);
    logic [M-1:0]    g, a, e;
    logic            c, s, w;
    logic [WORD-1:0] ad, dt;
    g = '0; a = '0; e = '0;
    c = 0; s = 0; w = 0;
    ad = '0; dt = '0;
    if (m_own >= 0) begin
      g[IW'(m_own)] = 1'b1;
      if (!m_abort) begin
        c  = bus.mstCyc_i[IW'(m_own)];
        s  = bus.mstStb_i[IW'(m_own)];
        w  = bus.mstWe_i[IW'(m_own)];
        ad = bus.mstAdr_i[IW'(m_own)];
        dt = bus.mstDat_i[IW'(m_own)];
        a[IW'(m_own)] = bus.ack_i & s;
`ifdef WB_TIMEOUT_EN
        e[IW'(m_own)] = s && !bus.ack_i &&
                        (m_cnt == TO - 1);
`endif
      end
    end
    chk(nm,
        {bus.mstGnt_o, bus.mstAck_o, bus.mstErr_o,
         bus.cyc_o, bus.stb_o, bus.we_o,
         bus.adr_o, bus.dat_o, bus.mstDat_o},
        {g, a, e, c, s, w, ad, dt, bus.dat_i});
  endtask

  task automatic model_step();
    int c;
    if (m_own < 0) begin
      for (int k = 1; k <= M; k++) begin
        c = (m_last + k) % M;
        if (m_own < 0 && bus.mstCyc_i[IW'(c)])
          m_own = c;
      end
    end else if (!bus.mstCyc_i[IW'(m_own)]) begin
      m_last  = m_own;
      m_own   = -1;
      m_abort = 1'b0;
      m_cnt   = 0;
    end else begin
`ifdef WB_TIMEOUT_EN
      if (!m_abort) begin
        if (bus.mstStb_i[IW'(m_own)] && !bus.ack_i) begin
          if (m_cnt == TO - 1) begin
            m_abort = 1'b1;
            m_cnt   = 0;
          end else begin
            m_cnt++;
          end
        end else begin
          m_cnt = 0;
        end
      end
`endif
    end
  endtask

  initial begin
    logic [M-1:0] g, prev_g;
    int           held [M];
    logic [M-1:0] seen [$];
    logic [M-1:0] rr_exp [4];
    logic [M-1:0] got;
    int           err_at;
    int           n;

    clr_inputs();
    model_reset();

    tbl[0] = '{2'b00, 2'b00, 2'b00, 0, 16'h0000,
               2'b00, 0, 2'b00, 16'h0000};
    tbl[1] = '{2'b10, 2'b10, 2'b10, 0, 16'h0000,
               2'b00, 0, 2'b00, 16'h0000};
    tbl[2] = '{2'b10, 2'b10, 2'b00, 1, 16'hBEEF,
               2'b10, 1, 2'b10, 16'h2000};
    tbl[3] = '{2'b11, 2'b11, 2'b00, 1, 16'hBEEF,
               2'b10, 1, 2'b10, 16'h2000};
    tbl[4] = '{2'b01, 2'b01, 2'b00, 0, 16'h0000,
               2'b10, 0, 2'b00, 16'h2000};
    tbl[5] = '{2'b01, 2'b01, 2'b00, 0, 16'h0000,
               2'b00, 0, 2'b00, 16'h0000};
    tbl[6] = '{2'b01, 2'b01, 2'b00, 1, 16'hBEEF,
               2'b01, 1, 2'b01, 16'h1000};
    tbl[7] = '{2'b00, 2'b00, 2'b00, 1, 16'hBEEF,
               2'b01, 0, 2'b00, 16'h1000};
    tbl[8] = '{2'b00, 2'b00, 2'b00, 1, 16'h1234,
               2'b00, 0, 2'b00, 16'h0000};

    // reset state
    #12;
    chk("rst gnt", bus.mstGnt_o, 0);
    chk("rst cyc", bus.cyc_o, 0);
    chk("rst ack", bus.mstAck_o, 0);
    chk("rst adr", bus.adr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      bus.mstAdr_i[0] = 16'h1000;
      bus.mstAdr_i[1] = 16'h2000;
      bus.mstCyc_i = tbl[v].cyc;
      bus.mstStb_i = tbl[v].stb;
      bus.mstWe_i  = tbl[v].we;
      bus.ack_i    = tbl[v].ack;
      bus.dat_i    = tbl[v].dat;
      #1;
      chk($sformatf("v%0d gnt", v),
          bus.mstGnt_o, tbl[v].gnt);
      chk($sformatf("v%0d cyc", v),
          bus.cyc_o, tbl[v].cyc_o);
      chk($sformatf("v%0d ack", v),
          bus.mstAck_o, tbl[v].ack_o);
      chk($sformatf("v%0d adr", v),
          bus.adr_o, tbl[v].adr);
      chk($sformatf("v%0d mdat", v),
          bus.mstDat_o, tbl[v].dat);
    end

    // both masters contend, 3-cycle tenures
    do_reset();
    prev_g = '0;
    for (int i = 0; i < M; i++) held[i] = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      #1;
      g = bus.mstGnt_o;
      chk("rr onehot", $onehot0(g), 1);
      if (g != 0 && g != prev_g) begin
        chk("rr idle gap", prev_g, 0);
        seen.push_back(g);
      end
      prev_g = g;
      for (int i = 0; i < M; i++) begin
        held[i] = g[i] ? held[i] + 1 : 0;
        bus.mstCyc_i[i] = (held[i] <= 3);
        bus.mstStb_i[i] = (held[i] <= 3);
      end
    end
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    chk("rr count", seen.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      got = (i < seen.size()) ? seen[i] : 'x;
      chk($sformatf("rr grant%0d", i), got, rr_exp[i]);
    end

    // reset during a write by master 1
    do_reset();
    @(negedge clk);
    bus.mstCyc_i = 2'b10;
    bus.mstStb_i = 2'b10;
    bus.mstWe_i  = 2'b10;
    bus.mstAdr_i[1] = 16'h0042;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid wr cyc", {bus.cyc_o, bus.we_o}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst cyc",
        {bus.cyc_o, bus.stb_o, bus.mstGnt_o}, 0);
    bus.mstCyc_i = 2'b11;
    bus.mstStb_i = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post rst gnt", bus.mstGnt_o, 2'b01);

    // owner strobes without any ack
    do_reset();
    @(negedge clk);
    bus.mstCyc_i = 2'b01;
    bus.mstStb_i = 2'b01;
    n = 0;
    while (bus.mstGnt_o != 2'b01 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall gnt seen", n < 10, 1);
    #1;
    err_at = 0;
    for (int c = 1; c <= 20 && err_at == 0; c++) begin
      if (bus.mstErr_o != 0) err_at = c;
      if (err_at == 0) begin
        @(negedge clk);
        #1;
      end
    end
`ifdef WB_TIMEOUT_EN
    chk("tmo err cycle", err_at, TO);
    chk("tmo err bits", bus.mstErr_o, 2'b01);
    @(negedge clk);
    #1;
    chk("abort bus",
        {bus.mstGnt_o, bus.cyc_o, bus.stb_o},
        {2'b01, 1'b0, 1'b0});
    bus.mstCyc_i = 2'b00;
    @(negedge clk);
    #1;
    chk("abort idle", bus.mstGnt_o, 0);
`else
    chk("no err", err_at, 0);
    chk("unbounded cyc", bus.cyc_o, 1);
`endif

    // randomized run against the model
    do_reset();
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      for (int i = 0; i < M; i++) begin
        if ($urandom_range(5) == 0)
          bus.mstCyc_i[i] = ~bus.mstCyc_i[i];
        bus.mstStb_i[i] = ($urandom_range(3) != 0);
        bus.mstWe_i[i]  = 1'($urandom);
        bus.mstAdr_i[i] = 16'($urandom);
        bus.mstDat_i[i] = 16'($urandom);
      end
`ifdef WB_TIMEOUT_EN
      bus.ack_i = ($urandom_range(15) == 0);
`else
      bus.ack_i = ($urandom_range(2) == 0);
`endif
      bus.dat_i = 16'($urandom);
      #1;
      model_check("rand");
      @(posedge clk);
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
